xo_tune_sequencer: RTL and testbench

//  Supervises the on-board XO discipline loop in the Clk (12.288 MHz XO) domain.
//  - Qualifies the 10 MHz reference by frequency-counting a divided copy of it.
//  - Sequences the XO tune mux through CENTER -> ACQUIRE -> LOCKED, using the
//    PLL lock flag.
//  - Retries failed acquisitions and flags a fault after repeated failures.
//  - Replaces the simple "ref ever high" presence check with a

---
 rtl/xo_tune_sequencer_if.sv | 24 ++
 rtl/xo_tune_sequencer.sv | 166 ++++++++++++++++
 tb/tb_xo_tune_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/xo_tune_sequencer_if.sv
// Pin bundle between the XO tune sequencer and the board-level loop:
// async reference/lock inputs in, tune mux select and status out.
interface xo_tune_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             Ref_Toggle;
  logic             Pll_Lock;
  logic             Tune_Sel;
  logic             Ref_OK;
  logic             Lock_OK;
  logic             Fault;
  logic [1:0]       State;
  logic [CNT_W-1:0] Ref_Count;

  modport slave (
    input  Ref_Toggle, Pll_Lock,
    output Tune_Sel, Ref_OK, Lock_OK, Fault, State, Ref_Count
  );

  modport master (
    output Ref_Toggle, Pll_Lock,
    input  Tune_Sel, Ref_OK, Lock_OK, Fault, State, Ref_Count
  );
endinterface

// File: rtl/xo_tune_sequencer.sv
// XO discipline supervisor: window-qualifies the divided reference, then
// walks the tune mux CENTER -> ACQUIRE -> LOCKED with retry/fault handling.
module xo_tune_sequencer #(
  parameter int WIN_LEN     = 12288,
  parameter int EXP_EDGES   = 1250,
  parameter int EDGE_TOL    = 4,
  parameter int LOCK_QUAL   = 4,
  parameter int ACQ_TIMEOUT = 64,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  xo_tune_sequencer_if.slave  bus
);

  localparam int TW  = $clog2(WIN_LEN);
  localparam int QW  = $clog2(LOCK_QUAL + 1);
  localparam int TOW = $clog2(ACQ_TIMEOUT + 1);
  localparam int RW  = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] GOOD_LO = CNT_W'(EXP_EDGES - EDGE_TOL);
  localparam logic [CNT_W-1:0] GOOD_HI = CNT_W'(EXP_EDGES + EDGE_TOL);

  typedef enum logic [1:0] {
    S_CENTER = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCK   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  logic             ref_s1_q, ref_s2_q, ref_s3_q;
  logic             lk_s1_q, lk_s2_q;
  logic [TW-1:0]    timer_q;
  logic [CNT_W-1:0] cnt_q, cnt_fin, ref_cnt_q;
  logic             good_prev_q, ref_ok_q, lk_all_q;
  logic             ref_edge, lk, win_tick, good, ref_fall, lk_whole;

  state_t           state_q, state_d;
  logic [QW-1:0]    qual_q, qual_d;
  logic [TOW-1:0]   to_q, to_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             tune_q, lock_ok_q, fault_q;

  assign ref_edge = ref_s2_q ^ ref_s3_q;
  assign lk       = lk_s2_q;
  assign win_tick = (timer_q == TW'(WIN_LEN - 1));
  // An edge landing on the tick cycle still belongs to the closing window.
  assign cnt_fin  = (ref_edge && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  assign good     = (cnt_fin >= GOOD_LO) && (cnt_fin <= GOOD_HI);
  assign ref_fall = win_tick && ref_ok_q && !good;
  assign lk_whole = lk_all_q & lk;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ref_s1_q    <= 1'b0;
      ref_s2_q    <= 1'b0;
      ref_s3_q    <= 1'b0;
      lk_s1_q     <= 1'b0;
      lk_s2_q     <= 1'b0;
      timer_q     <= '0;
      cnt_q       <= '0;
      ref_cnt_q   <= '0;
      good_prev_q <= 1'b0;
      ref_ok_q    <= 1'b0;
      lk_all_q    <= 1'b0;
    end else begin
      ref_s1_q <= bus.Ref_Toggle;
      ref_s2_q <= ref_s1_q;
      ref_s3_q <= ref_s2_q;
      lk_s1_q  <= bus.Pll_Lock;
      lk_s2_q  <= lk_s1_q;
      if (win_tick) begin
        timer_q     <= '0;
        cnt_q       <= '0;
        ref_cnt_q   <= cnt_fin;
        good_prev_q <= good;
        ref_ok_q    <= good & good_prev_q;
        lk_all_q    <= 1'b1;
      end else begin
        timer_q  <= timer_q + 1'b1;
        cnt_q    <= cnt_fin;
        lk_all_q <= lk_all_q & lk;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    to_d    = to_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      S_CENTER: begin
        qual_d = '0;
        to_d   = '0;
        if (ref_ok_q) state_d = S_ACQ;
      end
      S_ACQ: begin
        if (win_tick) begin
          qual_d = lk_whole ? qual_q + 1'b1 : '0;
          to_d   = to_q + 1'b1;
          // Lock and timeout counters restart per attempt, so a later
          // lock loss begins a fresh acquisition.
          if (qual_d >= QW'(LOCK_QUAL)) begin
            state_d = S_LOCK;
            retry_d = '0;
            qual_d  = '0;
            to_d    = '0;
          end else if (to_d >= TOW'(ACQ_TIMEOUT)) begin
            retry_d = retry_q + 1'b1;
            state_d = (retry_d >= RW'(MAX_RETRY)) ? S_FAULT : S_CENTER;
          end
        end
      end
      S_LOCK: begin
        if (!lk) state_d = S_ACQ;
      end
      S_FAULT: begin
        if (win_tick && !ref_ok_q) lost_d = 1'b1;
        if (lost_q && ref_ok_q) begin
          state_d = S_CENTER;
          retry_d = '0;
          lost_d  = 1'b0;
        end
      end
      default: state_d = S_CENTER;
    endcase
    // Losing the reference overrides lock/timeout and leaves retry untouched.
    if (ref_fall && ((state_q == S_ACQ) || (state_q == S_LOCK))) begin
      state_d = S_CENTER;
      retry_d = retry_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_CENTER;
      qual_q    <= '0;
      to_q      <= '0;
      retry_q   <= '0;
      lost_q    <= 1'b0;
      tune_q    <= 1'b0;
      lock_ok_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      qual_q    <= qual_d;
      to_q      <= to_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      tune_q    <= (state_d == S_ACQ) || (state_d == S_LOCK);
      lock_ok_q <= (state_d == S_LOCK);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  assign bus.Tune_Sel  = tune_q;
  assign bus.Ref_OK    = ref_ok_q;
  assign bus.Lock_OK   = lock_ok_q;
  assign bus.Fault     = fault_q;
  assign bus.State     = state_q;
  assign bus.Ref_Count = ref_cnt_q;

endmodule

// File: tb/tb_xo_tune_sequencer.sv
// Directed bench for xo_tune_sequencer with a shortened window so that
// multi-window timeout/fault sequences fit in a short run.
module tb_xo_tune_sequencer;
  localparam int WIN = 200;
  localparam int EXP = 50;
  localparam int TOL = 4;
  localparam int LQ  = 4;
  localparam int ATO = 8;
  localparam int MR  = 3;
  localparam int CW  = 16;

  localparam int ST_CENTER = 0;
  localparam int ST_ACQ    = 1;
  localparam int ST_LOCK   = 2;
  localparam int ST_FAULT  = 3;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  xo_tune_sequencer_if #(.CNT_W(CW)) bus();

  xo_tune_sequencer #(
    .WIN_LEN(WIN), .EXP_EDGES(EXP), .EDGE_TOL(TOL), .LOCK_QUAL(LQ),
    .ACQ_TIMEOUT(ATO), .MAX_RETRY(MR), .CNT_W(CW)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  // One full window of n reference toggles (spaced 2 Clk); optional 1-Clk
  // lock dropout at cycle 'drop' with the 3-Clk response checked inline.
  task automatic win(input int n, input int drop = -1);
    for (int i = 0; i < WIN; i++) begin
      if ((i < 2 * n) && (i % 2 == 0)) bus.Ref_Toggle = ~bus.Ref_Toggle;
      if (i == drop) bus.Pll_Lock = 1'b0;
      else if ((drop >= 0) && (i == drop + 1)) bus.Pll_Lock = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      if ((drop >= 0) && (i == drop + 2)) begin
        chk("drop_state", bus.State, ST_ACQ);
        chk("drop_lock_ok", bus.Lock_OK, 0);
      end
    end
  endtask

  task automatic do_rst();
    Rst_n = 1'b0;
    bus.Ref_Toggle = 1'b0;
    cyc(3);
    Rst_n = 1'b1;
  endtask

  initial begin
    bus.Ref_Toggle = 1'b0;
    bus.Pll_Lock   = 1'b0;
    Rst_n = 1'b0;
    cyc(2);
    chk("rst_state", bus.State, ST_CENTER);
    chk("rst_tune", bus.Tune_Sel, 0);
    chk("rst_ref_ok", bus.Ref_OK, 0);
    chk("rst_lock_ok", bus.Lock_OK, 0);
    chk("rst_fault", bus.Fault, 0);
    chk("rst_count", bus.Ref_Count, 0);
    Rst_n = 1'b1;

    // Nominal qualification and lock
    bus.Pll_Lock = 1'b1;
    win(EXP);
    chk("t1_w1_ref_ok", bus.Ref_OK, 0);
    chk("t1_w1_count", bus.Ref_Count, EXP);
    win(EXP);
    chk("t1_w2_ref_ok", bus.Ref_OK, 1);
    chk("t1_w2_state", bus.State, ST_CENTER);
    win(EXP);
    chk("t1_w3_state", bus.State, ST_ACQ);
    chk("t1_w3_tune", bus.Tune_Sel, 1);
    chk("t1_w3_lock_ok", bus.Lock_OK, 0);
    win(EXP);
    win(EXP);
    chk("t1_w5_state", bus.State, ST_ACQ);
    win(EXP);
    chk("t1_w6_state", bus.State, ST_LOCK);
    chk("t1_w6_lock_ok", bus.Lock_OK, 1);
    chk("t1_w6_count", bus.Ref_Count, EXP);

    // One-cycle lock dropout, then relock after LQ clean windows
    win(EXP, 20);
    chk("t3_drop_win_state", bus.State, ST_ACQ);
    win(EXP);
    win(EXP);
    win(EXP);
    chk("t3_qual3_state", bus.State, ST_ACQ);
    win(EXP);
    chk("t3_relock_state", bus.State, ST_LOCK);
    chk("t3_relock_lock_ok", bus.Lock_OK, 1);

    // Count window boundaries
    win(EXP - TOL);
    chk("t2_lo_count", bus.Ref_Count, EXP - TOL);
    chk("t2_lo_ref_ok", bus.Ref_OK, 1);
    chk("t2_lo_state", bus.State, ST_LOCK);
    win(EXP + TOL);
    chk("t2_hi_count", bus.Ref_Count, EXP + TOL);
    chk("t2_hi_ref_ok", bus.Ref_OK, 1);
    win(EXP - TOL - 1);
    chk("t2_lo_bad_count", bus.Ref_Count, EXP - TOL - 1);
    chk("t2_lo_bad_ref_ok", bus.Ref_OK, 0);
    chk("t2_lo_bad_state", bus.State, ST_CENTER);
    chk("t2_lo_bad_tune", bus.Tune_Sel, 0);
    chk("t2_lo_bad_lock_ok", bus.Lock_OK, 0);
    win(EXP - TOL);
    chk("t2_requal1_ref_ok", bus.Ref_OK, 0);
    win(EXP + TOL + 1);
    chk("t2_hi_bad_count", bus.Ref_Count, EXP + TOL + 1);
    chk("t2_hi_bad_ref_ok", bus.Ref_OK, 0);
    win(EXP + TOL);
    chk("t2_requal2_ref_ok", bus.Ref_OK, 0);
    win(EXP - TOL);
    chk("t2_requal3_ref_ok", bus.Ref_OK, 1);

    // Repeated timeouts into FAULT, then reference loss/recovery
    bus.Pll_Lock = 1'b0;
    do_rst();
    win(EXP);
    win(EXP);
    chk("t4_ref_ok", bus.Ref_OK, 1);
    for (int w = 0; w < ATO - 1; w++) win(EXP);
    chk("t4_pre_to1_state", bus.State, ST_ACQ);
    win(EXP);
    chk("t4_to1_state", bus.State, ST_CENTER);
    chk("t4_to1_fault", bus.Fault, 0);
    for (int w = 0; w < 2 * ATO; w++) win(EXP);
    chk("t4_fault_state", bus.State, ST_FAULT);
    chk("t4_fault_flag", bus.Fault, 1);
    chk("t4_fault_tune", bus.Tune_Sel, 0);
    chk("t4_fault_lock_ok", bus.Lock_OK, 0);
    win(0);
    chk("t4_noref_count", bus.Ref_Count, 0);
    chk("t4_noref_ref_ok", bus.Ref_OK, 0);
    chk("t4_noref_state", bus.State, ST_FAULT);
    win(EXP);
    chk("t4_rq1_state", bus.State, ST_FAULT);
    win(EXP);
    chk("t4_rq2_ref_ok", bus.Ref_OK, 1);
    chk("t4_rq2_state", bus.State, ST_FAULT);
    win(EXP);
    chk("t4_exit_state", bus.State, ST_ACQ);
    chk("t4_exit_fault", bus.Fault, 0);
    chk("t4_exit_tune", bus.Tune_Sel, 1);
    for (int w = 0; w < ATO - 2; w++) win(EXP);
    chk("t4_post_pre_to_state", bus.State, ST_ACQ);
    win(EXP);
    chk("t4_post_to_state", bus.State, ST_CENTER);
    chk("t4_post_to_fault", bus.Fault, 0);

    // Reset in the middle of ACQUIRE
    do_rst();
    win(EXP);
    win(EXP);
    cyc(50);
    chk("t5_pre_state", bus.State, ST_ACQ);
    Rst_n = 1'b0;
    #1;
    chk("t5_rst_state", bus.State, ST_CENTER);
    chk("t5_rst_tune", bus.Tune_Sel, 0);
    chk("t5_rst_ref_ok", bus.Ref_OK, 0);
    chk("t5_rst_count", bus.Ref_Count, 0);
    bus.Ref_Toggle = 1'b0;
    cyc(2);
    Rst_n = 1'b1;
    win(EXP);
    chk("t5_w1_ref_ok", bus.Ref_OK, 0);
    chk("t5_w1_state", bus.State, ST_CENTER);
    chk("t5_w1_count", bus.Ref_Count, EXP);
    win(EXP);
    chk("t5_w2_ref_ok", bus.Ref_OK, 1);
    win(EXP);
    chk("t5_w3_state", bus.State, ST_ACQ);

    // Stuck reference
    do_rst();
    for (int w = 0; w < 3; w++) begin
      win(0);
      chk("t6_count", bus.Ref_Count, 0);
      chk("t6_ref_ok", bus.Ref_OK, 0);
      chk("t6_state", bus.State, ST_CENTER);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
